memwb_pipe_reg: RTL and testbench

Parametrised MEM/WB pipeline stage register for the CPU datapath. It replaces the fixed 16-bit free-running latch with a valid/ready-handshaked stage. The stage has configurable data and register-address widths, an optional 2-entry skid buffer, and synchronous flush. It also produces the final writeback data and commit strobe consumed by the register file.

---
 rtl/cpu_pipe_pkg.sv | 38 +++
 rtl/pipe_skid_buf.sv | 117 +++++++++++
 rtl/memwb_pipe_reg.sv | 60 ++++++
 tb/tb_memwb_pipe_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline types: default widths, MEM/WB beat payload, skid-buffer state.
package cpu_pipe_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned RD_W   = 4;

    // MEM/WB beat payload at the default datapath widths
    typedef struct packed {
        logic              wbs;
        logic [DATA_W-1:0] memData;
        logic [DATA_W-1:0] calcData;
        logic              ni;
        logic [RD_W-1:0]   rd;
    } memwb_payload_t;

    localparam int unsigned MEMWB_PW = $bits(memwb_payload_t);

    // Skid-buffer fill state; encoding equals the number of held beats
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // Number of beats held in a given state
    function automatic logic [1:0] occ_of(input skid_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline stage: 2-entry skid buffer (SKID=1) or single
// register with pass-through ready (SKID=0). Flush kills all held beats.
module pipe_skid_buf
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned PW   = 8,
    parameter bit          SKID = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data,
    output logic [1:0]    occupancy
);

    skid_state_t   st_q;
    skid_state_t   st_d;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [1:0]    occ_q;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;

    logic          accept_c;
    logic          retire_c;
    logic          load_main_c;
    logic          load_skid_c;
    logic          skid_to_main_c;

    // Handshake qualifiers; a beat presented during flush is never accepted
    assign accept_c = in_valid && in_ready && !flush;
    assign retire_c = out_valid_q && out_ready;

    // Next-state and payload-load decode
    always_comb begin
        st_d           = st_q;
        load_main_c    = 1'b0;
        load_skid_c    = 1'b0;
        skid_to_main_c = 1'b0;
        if (flush) begin
            st_d = EMPTY;
        end else begin
            case (st_q)
                EMPTY: begin
                    if (accept_c) begin
                        st_d        = ONE;
                        load_main_c = 1'b1;
                    end
                end
                ONE: begin
                    if (accept_c && retire_c) begin
                        load_main_c = 1'b1;
                    end else if (accept_c && SKID) begin
                        st_d        = TWO;
                        load_skid_c = 1'b1;
                    end else if (retire_c) begin
                        st_d = EMPTY;
                    end
                end
                TWO: begin
                    if (retire_c) begin
                        st_d           = ONE;
                        skid_to_main_c = 1'b1;
                    end
                end
                default: st_d = EMPTY;
            endcase
        end
    end

    // State and status flops, all derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            st_q        <= st_d;
            in_ready_q  <= (st_d != TWO);
            out_valid_q <= (st_d != EMPTY);
            occ_q       <= occ_of(st_d);
        end
    end

    // Head payload: loads on accept into main or on skid promotion only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
        end else if (skid_to_main_c) begin
            main_q <= skid_q;
        end else if (load_main_c) begin
            main_q <= in_data;
        end
    end

    // Skid payload: captures the beat that arrives while the head is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else if (load_skid_c) begin
            skid_q <= in_data;
        end
    end

    // Registered ready with a skid; pass-through ready without one
    assign in_ready  = SKID ? in_ready_q : (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

endmodule

// File: rtl/memwb_pipe_reg.sv
// MEM/WB stage register: packs the beat, buffers it, and produces the
// writeback data and register-file commit strobe from the head beat.
module memwb_pipe_reg #(
    parameter int unsigned DATA_W = cpu_pipe_pkg::DATA_W,
    parameter int unsigned RD_W   = cpu_pipe_pkg::RD_W,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wbs_in,
    input  logic [DATA_W-1:0] memData_in,
    input  logic [DATA_W-1:0] calcData_in,
    input  logic              ni_in,
    input  logic [RD_W-1:0]   rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wbs_out,
    output logic [DATA_W-1:0] memData_out,
    output logic [DATA_W-1:0] calcData_out,
    output logic              ni_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic              wb_commit,
    output logic [1:0]        occupancy
);

    localparam int unsigned PW = 1 + DATA_W + DATA_W + 1 + RD_W;

    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;

    // Field order matches the shared payload struct layout
    assign in_payload = {wbs_in, memData_in, calcData_in, ni_in, rd_in};

    pipe_skid_buf #(
        .PW   (PW),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload),
        .occupancy (occupancy)
    );

    assign {wbs_out, memData_out, calcData_out, ni_out, rd_out} = out_payload;

    // Writeback select and register-file write strobe
    assign wb_data_out = wbs_out ? memData_out : calcData_out;
    assign wb_commit   = out_valid && out_ready;

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Directed self-checking bench for memwb_pipe_reg (SKID=1 and SKID=0 builds).
`timescale 1ns/1ps
module tb_memwb_pipe_reg;

    logic        clk;
    logic        rst_n;

    // SKID=1 instance signals
    logic        flush, in_valid, in_ready, wbs_in, ni_in, out_valid, out_ready;
    logic [15:0] mem_in, calc_in;
    logic [3:0]  rd_in;
    logic        wbs_out, ni_out, wb_commit;
    logic [15:0] mem_out, calc_out, wb_data;
    logic [3:0]  rd_out;
    logic [1:0]  occ;

    // SKID=0 instance signals
    logic        s0_flush, s0_in_valid, s0_in_ready, s0_wbs_in, s0_ni_in, s0_out_valid, s0_out_ready;
    logic [15:0] s0_mem_in, s0_calc_in;
    logic [3:0]  s0_rd_in;
    logic        s0_wbs_out, s0_ni_out, s0_wb_commit;
    logic [15:0] s0_mem_out, s0_calc_out, s0_wb_data;
    logic [3:0]  s0_rd_out;
    logic [1:0]  s0_occ;

    int pass_cnt = 0;
    int total_cnt = 0;

    memwb_pipe_reg #(.DATA_W(16), .RD_W(4), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .wbs_in(wbs_in), .memData_in(mem_in), .calcData_in(calc_in),
        .ni_in(ni_in), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .wbs_out(wbs_out), .memData_out(mem_out), .calcData_out(calc_out),
        .ni_out(ni_out), .rd_out(rd_out),
        .wb_data_out(wb_data), .wb_commit(wb_commit), .occupancy(occ)
    );

    memwb_pipe_reg #(.DATA_W(16), .RD_W(4), .SKID(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(s0_flush),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready),
        .wbs_in(s0_wbs_in), .memData_in(s0_mem_in), .calcData_in(s0_calc_in),
        .ni_in(s0_ni_in), .rd_in(s0_rd_in),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready),
        .wbs_out(s0_wbs_out), .memData_out(s0_mem_out), .calcData_out(s0_calc_out),
        .ni_out(s0_ni_out), .rd_out(s0_rd_out),
        .wb_data_out(s0_wb_data), .wb_commit(s0_wb_commit), .occupancy(s0_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; land 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 0; in_valid = 0; wbs_in = 0; ni_in = 0; out_ready = 0;
        mem_in = '0; calc_in = '0; rd_in = '0;
        s0_flush = 0; s0_in_valid = 0; s0_wbs_in = 0; s0_ni_in = 0; s0_out_ready = 0;
        s0_mem_in = '0; s0_calc_in = '0; s0_rd_in = '0;
        step();
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (occ !== 2'd0) $display("FAIL rst_occ got %0d exp 0", occ); else pass_cnt++;
        total_cnt++; if (wb_data !== 16'h0000) $display("FAIL rst_wb_data got %h exp 0000", wb_data); else pass_cnt++;
        total_cnt++; if (rd_out !== 4'd0) $display("FAIL rst_rd_out got %0d exp 0", rd_out); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else pass_cnt++;
        total_cnt++; if (s0_in_ready !== 1'b1) $display("FAIL rst_s0_in_ready got %b exp 1", s0_in_ready); else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_beat();
        out_ready = 1; in_valid = 1; wbs_in = 1; mem_in = 16'h1234; calc_in = 16'hABCD; ni_in = 1; rd_in = 4'd3;
        step();
        in_valid = 0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got %b exp 1", out_valid); else pass_cnt++;
        total_cnt++; if (wb_data !== 16'h1234) $display("FAIL single_wb_data got %h exp 1234", wb_data); else pass_cnt++;
        total_cnt++; if (rd_out !== 4'd3) $display("FAIL single_rd_out got %0d exp 3", rd_out); else pass_cnt++;
        total_cnt++; if (ni_out !== 1'b1) $display("FAIL single_ni_out got %b exp 1", ni_out); else pass_cnt++;
        total_cnt++; if (wb_commit !== 1'b1) $display("FAIL single_commit got %b exp 1", wb_commit); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_drain got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_mux();
        out_ready = 1; in_valid = 1; wbs_in = 0; mem_in = 16'h1234; calc_in = 16'h9876; ni_in = 1; rd_in = 4'd3;
        step();
        in_valid = 0;
        total_cnt++; if (wb_data !== 16'h9876) $display("FAIL mux_wb_data got %h exp 9876", wb_data); else pass_cnt++;
        total_cnt++; if (mem_out !== 16'h1234) $display("FAIL mux_mem_out got %h exp 1234", mem_out); else pass_cnt++;
        step();
    endtask

    task automatic test_skid_fill();
        out_ready = 0; wbs_in = 0; in_valid = 1; calc_in = 16'h0001;
        step();
        total_cnt++; if (occ !== 2'd1) $display("FAIL fill_occ_a got %0d exp 1", occ); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL fill_rdy_a got %b exp 1", in_ready); else pass_cnt++;
        calc_in = 16'h0002;
        step();
        total_cnt++; if (occ !== 2'd2) $display("FAIL fill_occ_b got %0d exp 2", occ); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL fill_rdy_b got %b exp 0", in_ready); else pass_cnt++;
        calc_in = 16'h0003;
        step();
        total_cnt++; if (occ !== 2'd2) $display("FAIL fill_occ_hold got %0d exp 2", occ); else pass_cnt++;
        total_cnt++; if (wb_data !== 16'h0001) $display("FAIL fill_head_stable got %h exp 0001", wb_data); else pass_cnt++;
        out_ready = 1;
        #1;
        total_cnt++; if (wb_commit !== 1'b1 || wb_data !== 16'h0001) $display("FAIL drain_a commit %b data %h exp 1 0001", wb_commit, wb_data); else pass_cnt++;
        step();
        total_cnt++; if (wb_commit !== 1'b1 || wb_data !== 16'h0002) $display("FAIL drain_b commit %b data %h exp 1 0002", wb_commit, wb_data); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL drain_rdy got %b exp 1", in_ready); else pass_cnt++;
        step();
        in_valid = 0;
        total_cnt++; if (wb_commit !== 1'b1 || wb_data !== 16'h0003) $display("FAIL drain_c commit %b data %h exp 1 0003", wb_commit, wb_data); else pass_cnt++;
        total_cnt++; if (occ !== 2'd1) $display("FAIL drain_c_occ got %0d exp 1", occ); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL drain_empty got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_flush_full();
        out_ready = 0; wbs_in = 0; in_valid = 1; calc_in = 16'h0011;
        step();
        calc_in = 16'h0022;
        step();
        total_cnt++; if (occ !== 2'd2) $display("FAIL flush_pre_occ got %0d exp 2", occ); else pass_cnt++;
        flush = 1; calc_in = 16'h0033;
        step();
        flush = 0; in_valid = 0;
        total_cnt++; if (occ !== 2'd0) $display("FAIL flush_occ got %0d exp 0", occ); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b exp 1", in_ready); else pass_cnt++;
        out_ready = 1;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_beat_leak got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        out_ready = 0; wbs_in = 0; in_valid = 1; calc_in = 16'h0044;
        step();
        calc_in = 16'h0055;
        step();
        in_valid = 0;
        total_cnt++; if (occ !== 2'd2) $display("FAIL arst_pre_occ got %0d exp 2", occ); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (occ !== 2'd0) $display("FAIL arst_occ got %0d exp 0", occ); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready got %b exp 1", in_ready); else pass_cnt++;
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back_skid0();
        int commits;
        logic [1:0] occ_max;
        commits = 0;
        occ_max = 2'd0;
        s0_out_ready = 1; s0_wbs_in = 0;
        for (int i = 0; i < 10; i++) begin
            s0_in_valid = 1; s0_calc_in = 16'h0100 + 16'(i);
            step();
            if (s0_occ > occ_max) occ_max = s0_occ;
            if (s0_wb_commit === 1'b1) commits++;
            total_cnt++; if (s0_wb_commit !== 1'b1 || s0_wb_data !== 16'h0100 + 16'(i))
                $display("FAIL s0_b2b_%0d commit %b data %h exp 1 %h", i, s0_wb_commit, s0_wb_data, 16'h0100 + 16'(i));
            else pass_cnt++;
        end
        s0_in_valid = 0;
        total_cnt++; if (commits != 10) $display("FAIL s0_commit_count got %0d exp 10", commits); else pass_cnt++;
        total_cnt++; if (occ_max > 2'd1) $display("FAIL s0_occ_max got %0d exp <=1", occ_max); else pass_cnt++;
        step();
        // Stalled head blocks the single-entry stage combinationally
        s0_in_valid = 1; s0_calc_in = 16'h0777; s0_out_ready = 0;
        step();
        s0_in_valid = 0;
        total_cnt++; if (s0_in_ready !== 1'b0) $display("FAIL s0_stall_rdy got %b exp 0", s0_in_ready); else pass_cnt++;
        s0_out_ready = 1;
        #1;
        total_cnt++; if (s0_in_ready !== 1'b1) $display("FAIL s0_pass_rdy got %b exp 1", s0_in_ready); else pass_cnt++;
        step();
    endtask

    task automatic test_throughput_skid1();
        int commits;
        commits = 0;
        out_ready = 1; wbs_in = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; mem_in = 16'h0A00 + 16'(i);
            step();
            if (wb_commit === 1'b1 && wb_data === 16'h0A00 + 16'(i) && occ === 2'd1 && in_ready === 1'b1) commits++;
        end
        in_valid = 0;
        total_cnt++; if (commits != 5) $display("FAIL s1_throughput got %0d exp 5", commits); else pass_cnt++;
        step();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_mux();
        test_skid_fill();
        test_flush_full();
        test_async_reset();
        test_throughput_skid1();
        test_back_to_back_skid0();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
